// File: rtl/multiplicador_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiplicador_seq
// Brief    : Sequential shift-and-add multiplier with a Start/Pronto
//            handshake. Each cycle it does one WIDTH+1-bit addition into a
//            2*WIDTH+1-bit accumulator, giving a 2*WIDTH-bit product after a
//            fixed latency. The product feeds the HI/LO registers used by
//            MULT/MULTU.
// Options  : define MULT_SIGNED_EN to treat both operands as two's
//            complement. This adds a SINAL state that applies the product
//            sign and adds one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module multiplicador_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [WIDTH-1:0]     OperandoA,
   input  logic [WIDTH-1:0]     OperandoB,
   output logic [2*WIDTH-1:0]   Produto,
   output logic                 Pronto,
   output logic                 Ocupado
);

   localparam int              CW     = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIM   = 2'd2,
      SINAL = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH:0]     acc_q,   acc_d;     // {upper WIDTH+1 bits, multiplier/low bits}
   logic [CW-1:0]        cnt_q,   cnt_d;
   logic [2*WIDTH-1:0]   produto_q, produto_d;

   logic [WIDTH-1:0]     w_op_a;             // operands as loaded into the datapath
   logic [WIDTH-1:0]     w_op_b;
   logic [WIDTH+1:0]     w_sum;              // upper half + conditional multiplicand, carry kept
   logic [2*WIDTH:0]     w_shifted;          // accumulator after add and right shift

`ifdef MULT_SIGNED_EN
   logic                 sign_q, sign_d;

   // Operands are loaded as magnitudes. The most negative value maps to
   // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
   always_comb begin
      w_op_a = OperandoA[WIDTH-1] ? ((~OperandoA) + {{(WIDTH-1){1'b0}}, 1'b1}) : OperandoA;
      w_op_b = OperandoB[WIDTH-1] ? ((~OperandoB) + {{(WIDTH-1){1'b0}}, 1'b1}) : OperandoB;
   end
`else
   // Operands are used directly in the unsigned build.
   always_comb begin
      w_op_a = OperandoA;
      w_op_b = OperandoB;
   end
`endif

   // One shift-and-add step: conditional add into the upper half, then a
   // right shift that moves the adder carry into the accumulator MSB.
   always_comb begin
      w_sum     = {1'b0, acc_q[2*WIDTH:WIDTH]}
                + {2'b00, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
      w_shifted = {w_sum, acc_q[WIDTH-1:1]};
   end

   // Next-state logic and datapath control. Start is only honoured in IDLE.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      produto_d = produto_q;
`ifdef MULT_SIGNED_EN
      sign_d    = sign_q;
`endif
      case (state_q)
         IDLE: begin
            if (Start) begin
               mcand_d = w_op_a;
               acc_d   = {{(WIDTH+1){1'b0}}, w_op_b};
               cnt_d   = '0;
`ifdef MULT_SIGNED_EN
               sign_d  = OperandoA[WIDTH-1] ^ OperandoB[WIDTH-1];
`endif
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = w_shifted;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
`ifdef MULT_SIGNED_EN
               state_d   = SINAL;
`else
               produto_d = w_shifted[2*WIDTH-1:0];
               state_d   = FIM;
`endif
            end
         end
`ifdef MULT_SIGNED_EN
         SINAL: begin
            produto_d = sign_q ? ((~acc_q[2*WIDTH-1:0]) + {{(2*WIDTH-1){1'b0}}, 1'b1})
                               : acc_q[2*WIDTH-1:0];
            state_d   = FIM;
         end
`endif
         FIM: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset takes priority over everything.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         produto_q <= '0;
`ifdef MULT_SIGNED_EN
         sign_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         produto_q <= produto_d;
`ifdef MULT_SIGNED_EN
         sign_q    <= sign_d;
`endif
      end
   end

   assign Produto = produto_q;
   assign Pronto  = (state_q == FIM);
   assign Ocupado = (state_q != IDLE);

endmodule
`default_nettype wire
